ks_note_sequencer: RTL and testbench
====================================

// Module: ks_note_sequencer
// PURPOSE
//  Sequences one ks_string voice from a queue of note commands. Latches per-note
//  config (period, drum/string, dynamics). Drives the pluck and noise-burst
//  window at full clock rate, then gates the string with freeze_o so it advances
//  once per sample tick. Sits between the host/MIDI command decoder and ks_string.
// PARAMETERS
//  MAX_LENGTH   64  wavetable length of the driven ks_string; period_o upper clamp
//  DATA_WIDTH   8   width of period and dynamics R
//  DUR_WIDTH    16  note duration width, in sample ticks
//  DIV_WIDTH    16  sample-rate divider width
//  FIFO_DEPTH   4   command queue depth (power of 2, >=2)
//  PLUCK_CYCLES 3   cycles pluck_o is held high
//  BURST_MARGIN 2   extra unfrozen cycles after the burst, beyond period
// PORTS
//  clk_i          in  1          clock
//  rst_n          in  1          reset, synchronous, active-low
//  cmd_valid_i    in  1          note command valid
//  cmd_ready_o    out 1          queue can accept a command
//  cmd_period_i   in  DATA_WIDTH requested period in samples
//  cmd_dur_i      in  DUR_WIDTH  note duration in sample ticks
//  cmd_drum_i     in  1          1=drum, 0=string
//  cmd_dyn_en_i   in  1          dynamics filter enable
//  cmd_dyn_R_i    in  DATA_WIDTH dynamics coefficient
//  sample_div_i   in  DIV_WIDTH  clocks per sample tick; 0 and 1 mean every cycle
//  abort_i        in  1          flush queue, return to IDLE
//  stop_i         in  1          end SUSTAIN, return to IDLE
//  pluck_o        out 1          to ks_string pluck_i
//  freeze_o       out 1          to ks_string freeze_i
//  period_o       out DATA_WIDTH to ks_string period_i
//  drum_string_no out 1          to ks_string drum_string_ni
//  dyn_en_o       out 1          to ks_string dynamics_en_i
//  dyn_R_o        out DATA_WIDTH to ks_string dynamics_R_i
//  sample_strobe_o out 1         ks_sample_o valid this cycle (PLAY/SUSTAIN tick)
//  note_done_o    out 1          1-cycle pulse when the duration expires
//  busy_o         out 1          state != IDLE
// BEHAVIOUR
//  Reset values: pluck_o=0, freeze_o=1, period_o=2, drum_string_no=0, dyn_en_o=0,
//   dyn_R_o=0, sample_strobe_o=0, note_done_o=0, busy_o=0, queue empty, state IDLE.
//   cmd_ready_o=0 while rst_n=0; 1 on the first cycle after reset.
//  Queue: push on cmd_valid_i&&cmd_ready_o. cmd_ready_o = !full && !abort_i.
//   No bypass: when full, ready stays low even if a pop happens that cycle.
//  FSM (registered outputs):
//   IDLE: freeze_o=1, pluck_o=0. Queue non-empty -> LOAD.
//   LOAD (1 cycle): pop the queue. Latch config outputs. Period is clamped to
//    [2,MAX_LENGTH]; duration 0 becomes 1. -> PLUCK.
//    Config outputs change only in LOAD.
//   PLUCK: pluck_o=1, freeze_o=0 for PLUCK_CYCLES cycles. -> BURST.
//   BURST: pluck_o=0, freeze_o=0 for period_o+BURST_MARGIN cycles. -> PLAY.
//   PLAY: the divider restarts at 0 on entry. Tick = divider at sample_div_i-1.
//    freeze_o=!tick, sample_strobe_o=tick. Count ticks. When count reaches the
//    duration: note_done_o=1 in the same cycle as the final strobe. Then, if the
//    queue is non-empty -> LOAD, else -> SUSTAIN.
//   SUSTAIN: same tick gating as PLAY, no counting; the string decays freely.
//    Queue non-empty -> LOAD (priority over stop_i). stop_i -> IDLE.
//  abort_i: from any state, next cycle is IDLE with pluck_o=0, freeze_o=1, queue
//   flushed, no note_done_o. Abort overrides a simultaneous push.
//  sample_div_i change mid-note takes effect at the next divider wrap. If the
//   divider exceeds the new value, it wraps to 0.
//  Counters saturate; no wrap-around inside a state.
// STRUCTURE
//  ks_pkg: state enum (IDLE,LOAD,PLUCK,BURST,PLAY,SUSTAIN) and the note command
//   struct {period,dur,drum,dyn_en,dyn_R}.
//  Sub-module ks_cmd_fifo: synchronous FIFO of the command struct, with full and
//   empty flags and a flush input.
//  Top level: FSM, shared phase counter (pluck/burst/duration), sample divider.
// TESTING
//  1) Reset, then push {period=10,dur=3,div=4} -> LOAD 1 cycle; pluck_o high 3 cycles;
//     freeze_o low 15 cycles in total; then 3 strobes 4 clks apart; note_done_o on
//     the 3rd strobe; SUSTAIN.
//  2) Push 5 commands back to back, none popped -> cmd_ready_o drops after the 4th;
//     the 5th is held until the first LOAD frees a slot.
//  3) period=0 and period=255 with MAX_LENGTH=64 -> period_o=2 and 64; dur=0 ->
//     exactly 1 strobe, then note_done_o.
//  4) abort_i during BURST with 2 queued -> next cycle IDLE, freeze_o=1, pluck_o=0,
//     queue empty, no note_done_o.
//  5) Second command queued during PLAY -> LOAD directly after note_done_o, no
//     SUSTAIN. A command arriving in SUSTAIN together with stop_i -> LOAD wins.
//  6) sample_div_i=0 in PLAY -> strobe every cycle; freeze_o held 0.

Source files
------------

// File: rtl/ks_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ks_pkg
// Description : Shared types for the Karplus-Strong note sequencer: FSM state
//               encoding and the queued note command record.
// Revision    : 1.0 - initial release
// ============================================================================
package ks_pkg;

    // Field widths of the queued command record. The sequencer's DATA_WIDTH
    // and DUR_WIDTH parameters default to these and must stay equal to them.
    localparam int KS_DATA_WIDTH = 8;
    localparam int KS_DUR_WIDTH  = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_PLUCK   = 3'd2,
        S_BURST   = 3'd3,
        S_PLAY    = 3'd4,
        S_SUSTAIN = 3'd5
    } ks_state_e;

    typedef struct packed {
        logic [KS_DATA_WIDTH-1:0] period;
        logic [KS_DUR_WIDTH-1:0]  dur;
        logic                     drum;
        logic                     dyn_en;
        logic [KS_DATA_WIDTH-1:0] dyn_R;
    } ks_note_cmd_t;

endpackage
`default_nettype wire

// File: rtl/ks_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ks_cmd_fifo
// Description : Synchronous FIFO of note commands with full/empty flags and a
//               flush that empties it in one cycle. Read data is the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module ks_cmd_fifo
    import ks_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  ks_note_cmd_t data_i,
    input  logic         pop_i,
    output ks_note_cmd_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int c_aw = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [c_aw:0]  wr_ptr_q;
    logic [c_aw:0]  rd_ptr_q;
    ks_note_cmd_t   mem_q [DEPTH];

    logic           w_full;
    logic           w_empty;
    logic           w_do_push;
    logic           w_do_pop;

    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                       (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
    assign w_do_push = push_i && !w_full && !flush_i;
    assign w_do_pop  = pop_i && !w_empty && !flush_i;

    // Pointer update; flush discards every stored entry.
    always_ff @(posedge clk_i) begin
        if (!rst_n || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + (c_aw+1)'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + (c_aw+1)'(1);
        end
    end

    // Entry storage; data needs no reset since the pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q[c_aw-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q[c_aw-1:0]];
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: rtl/ks_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ks_note_sequencer
// Description : Plays queued note commands on one ks_string voice: latches the
//               note config, runs the pluck and noise-burst window unfrozen,
//               then releases the string once per sample tick for the note
//               duration and lets it decay in SUSTAIN.
// Revision    : 1.0 - initial release
// ============================================================================
module ks_note_sequencer
    import ks_pkg::*;
#(
    parameter int MAX_LENGTH   = 64,
    parameter int DATA_WIDTH   = KS_DATA_WIDTH,
    parameter int DUR_WIDTH    = KS_DUR_WIDTH,
    parameter int DIV_WIDTH    = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int PLUCK_CYCLES = 3,
    parameter int BURST_MARGIN = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] cmd_period_i,
    input  logic [DUR_WIDTH-1:0]  cmd_dur_i,
    input  logic                  cmd_drum_i,
    input  logic                  cmd_dyn_en_i,
    input  logic [DATA_WIDTH-1:0] cmd_dyn_R_i,
    input  logic [DIV_WIDTH-1:0]  sample_div_i,
    input  logic                  abort_i,
    input  logic                  stop_i,
    output logic                  pluck_o,
    output logic                  freeze_o,
    output logic [DATA_WIDTH-1:0] period_o,
    output logic                  drum_string_no,
    output logic                  dyn_en_o,
    output logic [DATA_WIDTH-1:0] dyn_R_o,
    output logic                  sample_strobe_o,
    output logic                  note_done_o,
    output logic                  busy_o
);

    localparam logic [DATA_WIDTH-1:0] c_min_period = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] c_max_period = DATA_WIDTH'(MAX_LENGTH);
    localparam logic [DUR_WIDTH-1:0]  c_pluck_last = DUR_WIDTH'(PLUCK_CYCLES - 1);

    ks_state_e             state_q;
    logic [DUR_WIDTH-1:0]  phase_q;     // cycles in PLUCK/BURST, ticks in PLAY
    logic [DIV_WIDTH-1:0]  dcnt_q;      // sample divider position this cycle
    logic [DUR_WIDTH-1:0]  dur_q;
    logic                  pluck_q;
    logic                  freeze_q;
    logic [DATA_WIDTH-1:0] period_q;
    logic                  drum_q;
    logic                  dyn_en_q;
    logic [DATA_WIDTH-1:0] dyn_R_q;
    logic                  strobe_q;
    logic                  done_q;

    ks_note_cmd_t          w_head;
    ks_note_cmd_t          w_cmd_in;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    logic [DATA_WIDTH-1:0] w_period_clamped;
    logic [DUR_WIDTH-1:0]  w_dur_fixed;
    logic [DUR_WIDTH-1:0]  w_burst_last;
    logic [DUR_WIDTH-1:0]  w_phase_inc;
    logic [DIV_WIDTH-1:0]  w_lim;
    logic [DIV_WIDTH-1:0]  w_div_run;
    logic                  w_tick_run;
    logic                  w_tick_entry;
    logic [DUR_WIDTH-1:0]  w_cnt_run;
    logic [DUR_WIDTH:0]    w_cnt_plus;
    logic                  w_done_run;

    // No bypass: a full queue refuses even when it pops this cycle.
    assign cmd_ready_o = rst_n && !w_full && !abort_i;
    assign w_push      = cmd_valid_i && cmd_ready_o;
    assign w_pop       = (state_q == S_LOAD);

    assign w_cmd_in = '{period: cmd_period_i, dur: cmd_dur_i, drum: cmd_drum_i,
                        dyn_en: cmd_dyn_en_i, dyn_R: cmd_dyn_R_i};

    ks_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .flush_i (abort_i),
        .push_i  (w_push),
        .data_i  (w_cmd_in),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Next-cycle config, phase and sample-tick values evaluated ahead of the edge
    // so every output can be registered.
    always_comb begin
        w_period_clamped = w_head.period;
        if (w_head.period < c_min_period)      w_period_clamped = c_min_period;
        else if (w_head.period > c_max_period) w_period_clamped = c_max_period;

        w_dur_fixed  = (w_head.dur == '0) ? DUR_WIDTH'(1) : w_head.dur;
        w_burst_last = DUR_WIDTH'(period_q) + DUR_WIDTH'(BURST_MARGIN - 1);
        w_phase_inc  = (phase_q == '1) ? phase_q : phase_q + DUR_WIDTH'(1);

        // A divider of 0 or 1 ticks every cycle. A divider sitting beyond a
        // newly lowered limit wraps to 0 instead of running on.
        w_lim        = (sample_div_i <= DIV_WIDTH'(1)) ? '0 : sample_div_i - DIV_WIDTH'(1);
        w_div_run    = (strobe_q || (dcnt_q >= w_lim)) ? '0 : dcnt_q + DIV_WIDTH'(1);
        w_tick_run   = (w_div_run == w_lim);
        w_tick_entry = (w_lim == '0);

        // Ticks completed including this cycle, then done when the next tick
        // is the last one of the note.
        w_cnt_run    = (strobe_q && (phase_q != '1)) ? phase_q + DUR_WIDTH'(1) : phase_q;
        w_cnt_plus   = {1'b0, w_cnt_run} + (DUR_WIDTH+1)'(1);
        w_done_run   = w_tick_run && (w_cnt_plus >= {1'b0, dur_q});
    end

    // Note sequencing FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            dcnt_q   <= '0;
            dur_q    <= DUR_WIDTH'(1);
            pluck_q  <= 1'b0;
            freeze_q <= 1'b1;
            period_q <= c_min_period;
            drum_q   <= 1'b0;
            dyn_en_q <= 1'b0;
            dyn_R_q  <= '0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (abort_i) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            pluck_q  <= 1'b0;
            freeze_q <= 1'b1;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pluck_q  <= 1'b0;
                    freeze_q <= 1'b1;
                    strobe_q <= 1'b0;
                    done_q   <= 1'b0;
                    if (!w_empty) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    period_q <= w_period_clamped;
                    dur_q    <= w_dur_fixed;
                    drum_q   <= w_head.drum;
                    dyn_en_q <= w_head.dyn_en;
                    dyn_R_q  <= w_head.dyn_R;
                    phase_q  <= '0;
                    pluck_q  <= 1'b1;
                    freeze_q <= 1'b0;
                    state_q  <= S_PLUCK;
                end
                S_PLUCK: begin
                    if (phase_q == c_pluck_last) begin
                        phase_q <= '0;
                        pluck_q <= 1'b0;
                        state_q <= S_BURST;
                    end else begin
                        phase_q <= w_phase_inc;
                    end
                end
                S_BURST: begin
                    if (phase_q == w_burst_last) begin
                        phase_q  <= '0;
                        dcnt_q   <= '0;
                        strobe_q <= w_tick_entry;
                        freeze_q <= !w_tick_entry;
                        done_q   <= w_tick_entry && (dur_q == DUR_WIDTH'(1));
                        state_q  <= S_PLAY;
                    end else begin
                        phase_q <= w_phase_inc;
                    end
                end
                S_PLAY: begin
                    if (done_q) begin
                        done_q <= 1'b0;
                        if (!w_empty) begin
                            freeze_q <= 1'b1;
                            strobe_q <= 1'b0;
                            state_q  <= S_LOAD;
                        end else begin
                            dcnt_q   <= w_div_run;
                            strobe_q <= w_tick_run;
                            freeze_q <= !w_tick_run;
                            state_q  <= S_SUSTAIN;
                        end
                    end else begin
                        dcnt_q   <= w_div_run;
                        phase_q  <= w_cnt_run;
                        strobe_q <= w_tick_run;
                        freeze_q <= !w_tick_run;
                        done_q   <= w_done_run;
                    end
                end
                S_SUSTAIN: begin
                    if (!w_empty) begin
                        freeze_q <= 1'b1;
                        strobe_q <= 1'b0;
                        state_q  <= S_LOAD;
                    end else if (stop_i) begin
                        freeze_q <= 1'b1;
                        strobe_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        dcnt_q   <= w_div_run;
                        strobe_q <= w_tick_run;
                        freeze_q <= !w_tick_run;
                    end
                end
                default: begin
                    pluck_q  <= 1'b0;
                    freeze_q <= 1'b1;
                    strobe_q <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign pluck_o         = pluck_q;
    assign freeze_o        = freeze_q;
    assign period_o        = period_q;
    assign drum_string_no  = drum_q;
    assign dyn_en_o        = dyn_en_q;
    assign dyn_R_o         = dyn_R_q;
    assign sample_strobe_o = strobe_q;
    assign note_done_o     = done_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ks_note_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ks_note_sequencer
// Description : Self-checking bench for ks_note_sequencer: directed scenarios
//               and a random phase, compared every cycle against a timeline
//               model of the note sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ks_note_sequencer;

    localparam int MAX_LENGTH   = 64;
    localparam int DATA_WIDTH   = 8;
    localparam int DUR_WIDTH    = 16;
    localparam int DIV_WIDTH    = 16;
    localparam int FIFO_DEPTH   = 4;
    localparam int PLUCK_CYCLES = 3;
    localparam int BURST_MARGIN = 2;

    localparam int M_IDLE = 0, M_LOAD = 1, M_PLUCK = 2, M_BURST = 3, M_PLAY = 4, M_SUSTAIN = 5;

    logic                  clk_i = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  cmd_valid_i = 1'b0;
    logic                  cmd_ready_o;
    logic [DATA_WIDTH-1:0] cmd_period_i = '0;
    logic [DUR_WIDTH-1:0]  cmd_dur_i = '0;
    logic                  cmd_drum_i = 1'b0;
    logic                  cmd_dyn_en_i = 1'b0;
    logic [DATA_WIDTH-1:0] cmd_dyn_R_i = '0;
    logic [DIV_WIDTH-1:0]  sample_div_i = '0;
    logic                  abort_i = 1'b0;
    logic                  stop_i = 1'b0;
    logic                  pluck_o, freeze_o, drum_string_no, dyn_en_o;
    logic [DATA_WIDTH-1:0] period_o, dyn_R_o;
    logic                  sample_strobe_o, note_done_o, busy_o;

    always #5 clk_i = ~clk_i;

    ks_note_sequencer #(
        .MAX_LENGTH(MAX_LENGTH), .DATA_WIDTH(DATA_WIDTH), .DUR_WIDTH(DUR_WIDTH),
        .DIV_WIDTH(DIV_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PLUCK_CYCLES(PLUCK_CYCLES),
        .BURST_MARGIN(BURST_MARGIN)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_period_i(cmd_period_i), .cmd_dur_i(cmd_dur_i), .cmd_drum_i(cmd_drum_i),
        .cmd_dyn_en_i(cmd_dyn_en_i), .cmd_dyn_R_i(cmd_dyn_R_i), .sample_div_i(sample_div_i),
        .abort_i(abort_i), .stop_i(stop_i), .pluck_o(pluck_o), .freeze_o(freeze_o),
        .period_o(period_o), .drum_string_no(drum_string_no), .dyn_en_o(dyn_en_o),
        .dyn_R_o(dyn_R_o), .sample_strobe_o(sample_strobe_o), .note_done_o(note_done_o),
        .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Staged inputs: applied to the DUT at the next negedge by tick().
    int n_rst_n = 0, n_valid = 0, n_abort = 0, n_stop = 0, n_div = 0;
    int n_period = 0, n_dur = 0, n_drum = 0, n_dyn_en = 0, n_dyn_R = 0;

    // Reference model: note timeline measured in elapsed cycles and ticks.
    typedef struct { int period; int dur; int drum; int dyn_en; int dyn_R; } mcmd_t;
    mcmd_t mq[$];
    int m_mode = M_IDLE, m_t = 0, m_age = 0, m_cnt = 0, m_dur = 1;
    int e_pluck = 0, e_freeze = 1, e_period = 2, e_drum = 0, e_dyn_en = 0, e_dyn_R = 0;
    int e_strobe = 0, e_done = 0;

    // Last sampled DUT outputs, for directed scenario measurements.
    logic s_pluck, s_freeze, s_strobe, s_done, s_busy;
    logic [DATA_WIDTH-1:0] s_period;
    bit   chk_en = 0;
    bit   last_acc = 0;

    function automatic void play_tick(input bit counting);
        int l;
        l = (n_div <= 1) ? 1 : n_div;
        e_strobe = ((m_age % l) == 0);
        e_freeze = !e_strobe;
        if (counting && e_strobe) m_cnt++;
        e_done = counting && e_strobe && (m_cnt >= m_dur);
    endfunction

    function automatic void go_quiet(input int mode);
        m_mode = mode; e_pluck = 0; e_freeze = 1; e_strobe = 0; e_done = 0;
    endfunction

    function automatic void model_step(input bit push);
        int sz;
        mcmd_t c;
        if (n_rst_n == 0) begin
            mq.delete(); go_quiet(M_IDLE);
            e_period = 2; e_drum = 0; e_dyn_en = 0; e_dyn_R = 0;
            return;
        end
        if (n_abort != 0) begin
            mq.delete(); go_quiet(M_IDLE);
            return;
        end
        sz = mq.size();
        case (m_mode)
            M_IDLE: if (sz > 0) m_mode = M_LOAD;
            M_LOAD: begin
                c = mq.pop_front();
                e_period = (c.period < 2) ? 2 : ((c.period > MAX_LENGTH) ? MAX_LENGTH : c.period);
                e_drum = c.drum; e_dyn_en = c.dyn_en; e_dyn_R = c.dyn_R;
                m_dur = (c.dur == 0) ? 1 : c.dur;
                m_mode = M_PLUCK; m_t = 1; e_pluck = 1; e_freeze = 0;
            end
            M_PLUCK: begin
                if (m_t == PLUCK_CYCLES) begin m_mode = M_BURST; m_t = 1; e_pluck = 0; end
                else m_t++;
            end
            M_BURST: begin
                if (m_t == e_period + BURST_MARGIN) begin
                    m_mode = M_PLAY; m_age = 1; m_cnt = 0; play_tick(1);
                end else m_t++;
            end
            M_PLAY: begin
                if (e_done) begin
                    if (sz > 0) go_quiet(M_LOAD);
                    else begin m_mode = M_SUSTAIN; m_age++; play_tick(0); end
                end else begin
                    m_age++; play_tick(1);
                end
            end
            default: begin
                if (sz > 0) go_quiet(M_LOAD);
                else if (n_stop != 0) go_quiet(M_IDLE);
                else begin m_age++; play_tick(0); end
            end
        endcase
        if (push) mq.push_back('{period: n_period, dur: n_dur, drum: n_drum,
                                 dyn_en: n_dyn_en, dyn_R: n_dyn_R});
    endfunction

    task automatic tick();
        bit exp_ready;
        @(negedge clk_i);
        s_pluck = pluck_o; s_freeze = freeze_o; s_strobe = sample_strobe_o;
        s_done = note_done_o; s_busy = busy_o; s_period = period_o;
        if (chk_en) begin
            check_eq("pluck", pluck_o, e_pluck);
            check_eq("freeze", freeze_o, e_freeze);
            check_eq("period", period_o, e_period);
            check_eq("drum", drum_string_no, e_drum);
            check_eq("dyn_en", dyn_en_o, e_dyn_en);
            check_eq("dyn_R", dyn_R_o, e_dyn_R);
            check_eq("strobe", sample_strobe_o, e_strobe);
            check_eq("done", note_done_o, e_done);
            check_eq("busy", busy_o, (m_mode != M_IDLE));
        end
        rst_n = (n_rst_n != 0); cmd_valid_i = (n_valid != 0); abort_i = (n_abort != 0);
        stop_i = (n_stop != 0); sample_div_i = DIV_WIDTH'(n_div);
        cmd_period_i = DATA_WIDTH'(n_period); cmd_dur_i = DUR_WIDTH'(n_dur);
        cmd_drum_i = (n_drum != 0); cmd_dyn_en_i = (n_dyn_en != 0);
        cmd_dyn_R_i = DATA_WIDTH'(n_dyn_R);
        #1;
        exp_ready = (n_rst_n != 0) && (mq.size() < FIFO_DEPTH) && (n_abort == 0);
        if (chk_en) check_eq("ready", cmd_ready_o, exp_ready);
        last_acc = (n_valid != 0) && exp_ready;
        model_step(last_acc);
        @(posedge clk_i);
        chk_en = 1;
    endtask

    task automatic set_cmd(input int p, input int d, input int dr, input int en, input int r);
        n_period = p; n_dur = d; n_drum = dr; n_dyn_en = en; n_dyn_R = r;
    endtask

    task automatic push(input int p, input int d);
        set_cmd(p, d, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255));
        n_valid = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check_eq("push_timeout", 0, 1);
        n_valid = 0;
    endtask

    task automatic wait_mode(input int m);
        for (int i = 0; i < 400; i++) begin
            if (m_mode == m) return;
            tick();
        end
        check_eq("wait_timeout", m_mode, m);
    endtask

    task automatic pulse_abort();
        n_abort = 1; tick(); n_abort = 0; tick();
    endtask

    initial begin
        int pl, flo, ns, last, gap_bad, done_at, acc;

        // Reset
        n_rst_n = 0;
        repeat (3) tick();
        n_rst_n = 1;
        tick();

        // 1) period 10, dur 3, divider 4: pluck 3, 15 unfrozen, 3 strobes 4 apart
        n_div = 4;
        push(10, 3);
        pl = 0; flo = 0; ns = 0; last = 0; gap_bad = 0; done_at = -1;
        for (int i = 0; i < 100 && done_at < 0; i++) begin
            tick();
            if (s_pluck) pl++;
            if (ns == 0 && !s_freeze && !s_strobe) flo++;
            if (s_strobe) begin
                if (ns > 0 && (i - last) != 4) gap_bad++;
                last = i; ns++;
            end
            if (s_done) done_at = ns;
        end
        check_eq("t1_pluck_cycles", pl, 3);
        check_eq("t1_unfrozen_cycles", flo, 15);
        check_eq("t1_strobes", ns, 3);
        check_eq("t1_strobe_gap", gap_bad, 0);
        check_eq("t1_done_on_strobe", done_at, 3);
        tick();
        check_eq("t1_sustain_busy", s_busy, 1);
        n_stop = 1; tick(); n_stop = 0; tick();
        check_eq("t1_stop_idle", s_busy, 0);

        // 2) queue fill during a long note; fifth held until a LOAD frees a slot
        n_div = 2;
        push(10, 40);
        wait_mode(M_PLAY);
        set_cmd(5, 1, 0, 1, 7);
        n_valid = 1; acc = 0;
        repeat (5) begin tick(); acc += int'(last_acc); end
        check_eq("t2_accepted_of_5", acc, 4);
        for (int i = 0; i < 300 && !last_acc; i++) tick();
        check_eq("t2_fifth_after_load", s_pluck, 1);
        n_valid = 0;
        pulse_abort();

        // 3) period clamps and zero duration
        n_div = 1;
        push(0, 0);
        wait_mode(M_PLUCK); tick();
        check_eq("t3_period_lo", s_period, 2);
        ns = 0; done_at = 0;
        for (int i = 0; i < 100 && done_at == 0; i++) begin
            tick(); if (s_strobe) ns++; if (s_done) done_at = 1;
        end
        check_eq("t3_dur0_strobes", ns, 1);
        pulse_abort();
        push(255, 2);
        wait_mode(M_PLUCK); tick();
        check_eq("t3_period_hi", s_period, 64);
        pulse_abort();

        // 4) abort during BURST with two queued
        n_div = 2;
        push(60, 5);
        wait_mode(M_BURST);
        push(20, 2);
        push(30, 2);
        n_abort = 1; tick(); n_abort = 0; tick();
        check_eq("t4_busy", s_busy, 0);
        check_eq("t4_freeze", s_freeze, 1);
        check_eq("t4_pluck", s_pluck, 0);
        check_eq("t4_done", s_done, 0);
        for (int i = 0; i < 5; i++) begin tick(); check_eq("t4_queue_empty", s_busy, 0); end

        // 5) queued during PLAY goes straight to LOAD; queued+stop in SUSTAIN loads
        push(4, 3);
        wait_mode(M_PLAY);
        push(3, 2);
        done_at = 0;
        for (int i = 0; i < 100 && done_at == 0; i++) begin tick(); if (s_done) done_at = 1; end
        tick();
        check_eq("t5_load_busy", s_busy, 1);
        check_eq("t5_load_nostrobe", s_strobe, 0);
        tick();
        check_eq("t5_pluck_next", s_pluck, 1);
        wait_mode(M_SUSTAIN);
        push(6, 1);
        n_stop = 1; tick(); n_stop = 0; tick();
        check_eq("t5_load_beats_stop", s_busy, 1);
        tick();
        check_eq("t5_pluck_after_stop", s_pluck, 1);
        pulse_abort();

        // 6) divider 0: strobe every cycle while playing
        n_div = 0;
        push(3, 4);
        wait_mode(M_PLAY);
        ns = 0; pl = 0; done_at = 0;
        for (int i = 0; i < 50 && done_at == 0; i++) begin
            tick();
            if (s_strobe) ns++;
            if (s_freeze) pl++;
            if (s_done) done_at = 1;
        end
        check_eq("t6_strobes", ns, 4);
        check_eq("t6_freeze_high", pl, 0);
        pulse_abort();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            n_valid  = ($urandom_range(0, 3) == 0);
            set_cmd($urandom_range(0, 255), $urandom_range(0, 6), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 255));
            n_abort  = ($urandom_range(0, 79) == 0);
            n_stop   = ($urandom_range(0, 7) == 0);
            n_rst_n  = ($urandom_range(0, 999) != 0);
            if (m_mode == M_IDLE && $urandom_range(0, 3) == 0) n_div = $urandom_range(0, 5);
            tick();
        end
        n_valid = 0; n_abort = 0; n_stop = 0; n_rst_n = 1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
